// File: rtl/serial_pkg.sv
// Shared types for the serial word packer: FSM state encoding and default word width.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/packer_out_buf.sv
// One-entry output register with valid/ready handshake; a word offered while a
// previous one is still waiting is dropped and flagged on drop.
module packer_out_buf
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             drop
);

    assign drop = load & out_valid & ~out_ready;

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (load && (!out_valid || out_ready)) begin
            out_data  <= din;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_word_packer.sv
// Packs an LSB-first serial bit stream into WIDTH-bit words behind a one-entry output buffer.
// Optional macro PACKER_PARITY_EN adds an even-parity bit after each word and the parity_err port.
module serial_word_packer
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             x,
    input  logic             x_vld,
    input  logic             sof,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             overflow
`ifdef PACKER_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic             ferr_nxt;
    logic             load;
    logic [WIDTH-1:0] din;
    logic             drop;
`ifdef PACKER_PARITY_EN
    logic             perr_nxt;
`endif

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
`ifdef PACKER_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            shreg     <= shreg_nxt;
            frame_err <= ferr_nxt;
            if (drop)
                overflow <= 1'b1;
`ifdef PACKER_PARITY_EN
            parity_err <= perr_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        ferr_nxt  = 1'b0;
        load      = 1'b0;
        din       = shreg;
`ifdef PACKER_PARITY_EN
        perr_nxt  = 1'b0;
`endif
        // sof always restarts a word; mid-word it also discards the partial one
        if (x_vld && sof) begin
            ferr_nxt     = (state != IDLE);
            shreg_nxt    = '0;
            shreg_nxt[0] = x;
            cnt_nxt      = CW'(1);
            state_nxt    = SHIFT;
        end else if (x_vld) begin
            case (state)
                SHIFT: begin
                    shreg_nxt[cnt] = x;
                    if (cnt == CW'(WIDTH - 1)) begin
                        cnt_nxt = '0;
`ifdef PACKER_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = IDLE;
                        load      = 1'b1;
                        din       = shreg_nxt;
`endif
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
`ifdef PACKER_PARITY_EN
                PARITY: begin
                    state_nxt = IDLE;
                    if ((^shreg) ^ x)
                        perr_nxt = 1'b1;
                    else
                        load = 1'b1;
                end
`endif
                default: state_nxt = state;
            endcase
        end
    end

    packer_out_buf #(.WIDTH(WIDTH)) u_out_buf (
        .clk       (clk),
        .areset    (areset),
        .load      (load),
        .din       (din),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop      (drop)
    );

endmodule

// File: tb/tb_serial_word_packer.sv
// Directed scoreboard bench for serial_word_packer (default build, WIDTH=8).
module tb_serial_word_packer;

    logic       clk = 1'b0;
    logic       areset;
    logic       x, x_vld, sof;
    logic [7:0] out_data;
    logic       out_valid, out_ready;
    logic       frame_err, overflow;

    int total = 0;
    int bad = 0;
    int ferr_cnt = 0;
    logic [7:0] sb[$];

    serial_word_packer #(.WIDTH(8)) dut (
        .clk       (clk),
        .areset    (areset),
        .x         (x),
        .x_vld     (x_vld),
        .sof       (sof),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake must match the next queued word.
    always @(negedge clk) begin
        if (areset === 1'b1 && frame_err === 1'b1)
            ferr_cnt++;
        if (areset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_word: got 0x%0h expected none", out_data);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                if (out_data !== e) begin
                    bad++;
                    $display("FAIL word: got 0x%0h expected 0x%0h", out_data, e);
                end
            end
        end
    end

    task automatic bit_cycle(input logic v, input logic b, input logic s);
        x_vld = v;
        x     = b;
        sof   = s;
        @(posedge clk);
        #1;
        x_vld = 1'b0;
        sof   = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++)
            bit_cycle(1'b1, w[i], i == 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w;
        int f0;
        areset = 1'b0; x = 1'b0; x_vld = 1'b0; sof = 1'b0; out_ready = 1'b1;
        #2;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovf", overflow, 0);
        @(posedge clk); @(posedge clk); #1;
        areset = 1'b1;
        @(posedge clk); #1;

        // 0xA5, latency and single valid cycle
        w = 8'hA5;
        sb.push_back(w);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("a5_not_early", out_valid, 0);
            bit_cycle(1'b1, w[i], i == 0);
        end
        check("a5_valid", out_valid, 1);
        check("a5_data", out_data, 8'hA5);
        @(posedge clk); #1;
        check("a5_one_cycle", out_valid, 0);

        // back-to-back words
        f0 = ferr_cnt;
        sb.push_back(8'h3C);
        sb.push_back(8'hC3);
        send_word(8'h3C);
        send_word(8'hC3);
        check("b2b_valid", out_valid, 1);
        @(posedge clk); #1;
        check("b2b_ferr", ferr_cnt - f0, 0);

        // backpressure and overflow
        out_ready = 1'b0;
        send_word(8'h11);
        check("bp_valid", out_valid, 1);
        check("bp_data1", out_data, 8'h11);
        check("bp_ovf0", overflow, 0);
        send_word(8'h22);
        check("bp_ovf1", overflow, 1);
        check("bp_hold", out_data, 8'h11);
        sb.push_back(8'h11);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_drained", out_valid, 0);
        check("bp_ovf_sticky", overflow, 1);

        // completion in the same cycle as a handshake
        out_ready = 1'b0;
        sb.push_back(8'h33);
        sb.push_back(8'h44);
        send_word(8'h33);
        w = 8'h44;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) out_ready = 1'b1;
            bit_cycle(1'b1, w[i], i == 0);
        end
        check("swap_valid", out_valid, 1);
        check("swap_data", out_data, 8'h44);
        @(posedge clk); #1;

        // sof mid-word
        f0 = ferr_cnt;
        bit_cycle(1'b1, 1'b1, 1'b1);
        bit_cycle(1'b1, 1'b1, 1'b0);
        bit_cycle(1'b1, 1'b1, 1'b0);
        sb.push_back(8'h5A);
        send_word(8'h5A);
        check("ferr_data", out_data, 8'h5A);
        @(posedge clk); #1;
        check("ferr_pulses", ferr_cnt - f0, 1);

        // reset mid-word
        out_ready = 1'b0;
        bit_cycle(1'b1, 1'b1, 1'b1);
        bit_cycle(1'b1, 1'b0, 1'b0);
        bit_cycle(1'b1, 1'b1, 1'b0);
        bit_cycle(1'b1, 1'b0, 1'b0);
        areset = 1'b0;
        #2;
        check("mr_valid", out_valid, 0);
        check("mr_data", out_data, 0);
        check("mr_ferr", frame_err, 0);
        check("mr_ovf", overflow, 0);
        @(posedge clk); #1;
        areset = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            bit_cycle(1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("mr_ignore_no_sof", out_valid, 0);
        sb.push_back(8'hFF);
        send_word(8'hFF);
        check("ff_data", out_data, 8'hFF);
        @(posedge clk); #1;
        @(posedge clk); #1;

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
